// File: rtl/vram_pkg.sv
// Shared constants and host FSM encoding for the VGA frame-buffer blocks.
package vram_pkg;

   localparam int VRAM_ADDR_WIDTH   = 10;
   localparam int VRAM_DATA_WIDTH   = 4;
   localparam int VRAM_STARVE_LIMIT = 8;

   typedef enum logic [1:0] {
      H_IDLE = 2'd0,
      H_PEND = 2'd1,
      H_RESP = 2'd2
   } host_state_e;

   // Width of a counter that must hold the values 0..limit inclusive.
   function automatic int wait_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/vram_arb.sv
// Single-port VRAM arbiter: display reads win by default, the host gets a
// slot when the display is quiet or after STARVE_LIMIT blocked cycles.
module vram_arb
   import vram_pkg::*;
#(
   parameter int ADDR_WIDTH   = VRAM_ADDR_WIDTH,
   parameter int DATA_WIDTH   = VRAM_DATA_WIDTH,
   parameter int STARVE_LIMIT = VRAM_STARVE_LIMIT
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_disp_req,
   input  logic [ADDR_WIDTH-1:0] i_disp_addr,
   output logic [DATA_WIDTH-1:0] o_disp_data,
   output logic                  o_disp_valid,
   output logic                  o_disp_miss,
   input  logic                  i_host_valid,
   output logic                  o_host_ready,
   input  logic                  i_host_we,
   input  logic [ADDR_WIDTH-1:0] i_host_addr,
   input  logic [DATA_WIDTH-1:0] i_host_wdata,
   output logic [DATA_WIDTH-1:0] o_host_rdata,
   output logic                  o_host_done,
   output logic [ADDR_WIDTH-1:0] o_ram_addr,
   output logic [DATA_WIDTH-1:0] o_ram_wdata,
   output logic                  o_ram_we,
   input  logic [DATA_WIDTH-1:0] i_ram_data
);

   localparam int                WW       = wait_width(STARVE_LIMIT);
   localparam logic [WW-1:0]     WAIT_MAX = WW'(STARVE_LIMIT);

   host_state_e           state_q;
   logic [WW-1:0]         wait_q;
   logic                  hold_we_q;
   logic [ADDR_WIDTH-1:0] hold_addr_q;
   logic [DATA_WIDTH-1:0] hold_wdata_q;
   logic [DATA_WIDTH-1:0] host_rdata_q;
   logic                  disp_valid_q;
   logic                  disp_miss_q;
   logic                  host_done_q;

   logic starved;
   logic disp_gnt;
   logic host_gnt;

   // A pending host that has waited the full limit takes the port even
   // against an active display request.
   always_comb begin
      starved  = (state_q == H_PEND) && (wait_q == WAIT_MAX);
      disp_gnt = i_disp_req && !starved;
      host_gnt = (state_q == H_PEND) && !disp_gnt;
   end

   assign o_ram_addr   = disp_gnt ? i_disp_addr : hold_addr_q;
   assign o_ram_wdata  = hold_wdata_q;
   assign o_ram_we     = host_gnt && hold_we_q;
   assign o_host_ready = (state_q == H_IDLE);
   assign o_disp_data  = i_ram_data;
   assign o_disp_valid = disp_valid_q;
   assign o_disp_miss  = disp_miss_q;
   assign o_host_done  = host_done_q;
   assign o_host_rdata = host_rdata_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= H_IDLE;
         wait_q       <= '0;
         hold_we_q    <= 1'b0;
         hold_addr_q  <= '0;
         hold_wdata_q <= '0;
         host_rdata_q <= '0;
         disp_valid_q <= 1'b0;
         disp_miss_q  <= 1'b0;
         host_done_q  <= 1'b0;
      end else begin
         disp_valid_q <= disp_gnt;
         disp_miss_q  <= i_disp_req && starved;
         host_done_q  <= 1'b0;
         case (state_q)
            H_IDLE: begin
               if (i_host_valid) begin
                  hold_we_q    <= i_host_we;
                  hold_addr_q  <= i_host_addr;
                  hold_wdata_q <= i_host_wdata;
                  wait_q       <= '0;
                  state_q      <= H_PEND;
               end
            end
            H_PEND: begin
               if (host_gnt) begin
                  wait_q <= '0;
                  if (hold_we_q) begin
                     host_done_q <= 1'b1;
                     state_q     <= H_IDLE;
                  end else begin
                     state_q <= H_RESP;
                  end
               end else if (wait_q != WAIT_MAX) begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            // RAM data for the read granted last cycle is on i_ram_data now.
            H_RESP: begin
               host_rdata_q <= i_ram_data;
               host_done_q  <= 1'b1;
               state_q      <= H_IDLE;
            end
            default: state_q <= H_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vram_arb.sv
// Bench for vram_arb: directed scenarios against a preloaded RAM, then a
// random phase checked against a transaction-level timing model.
module tb_vram_arb;

   localparam int AW  = 10;
   localparam int DW  = 4;
   localparam int LIM = 8;
   localparam int N   = 400;
   localparam int T   = N + LIM + 6;
   localparam int M   = T + LIM + 6;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic          disp_req;
   logic [AW-1:0] disp_addr;
   logic [DW-1:0] disp_data;
   logic          disp_valid;
   logic          disp_miss;
   logic          host_valid;
   logic          host_ready;
   logic          host_we;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata;
   logic [DW-1:0] host_rdata;
   logic          host_done;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic          ram_we;
   logic [DW-1:0] ram_q;
   logic          ram_ld;

   always #5 clk = ~clk;

   vram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_disp_req  (disp_req),
      .i_disp_addr (disp_addr),
      .o_disp_data (disp_data),
      .o_disp_valid(disp_valid),
      .o_disp_miss (disp_miss),
      .i_host_valid(host_valid),
      .o_host_ready(host_ready),
      .i_host_we   (host_we),
      .i_host_addr (host_addr),
      .i_host_wdata(host_wdata),
      .o_host_rdata(host_rdata),
      .o_host_done (host_done),
      .o_ram_addr  (ram_addr),
      .o_ram_wdata (ram_wdata),
      .o_ram_we    (ram_we),
      .i_ram_data  (ram_q)
   );

   // Registered-read RAM beside the arbiter, preloaded with mem[a] = a[3:0].
   logic [DW-1:0] ram [0:1023];
   always @(posedge clk) begin
      if (ram_ld) begin
         for (int i = 0; i < 1024; i++) ram[i] <= i[DW-1:0];
      end else begin
         if (ram_we) ram[ram_addr] <= ram_wdata;
         ram_q <= ram[ram_addr];
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Transaction-level model state for the random phase.
   logic [DW-1:0] ref_mem [0:1023];
   bit            disp_pat [M];
   logic [AW-1:0] dpat_addr [M];
   bit            exp_valid [M];
   bit            exp_miss [M];
   bit            exp_done [M];
   bit            exp_we [M];
   bit            exp_isrd [M];
   bit            ovr [M];
   logic [DW-1:0] exp_ddata [M];
   logic [DW-1:0] exp_rd [M];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int free_at;
      int g;
      int d;
      bit hv;
      bit rdy;

      disp_req = 1'b0; disp_addr = '0;
      host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
      ram_ld = 1'b1;
      #2 rst_n = 1'b0;
      nxt(); nxt();
      chk("rst_disp_valid", 32'(disp_valid), 0);
      chk("rst_disp_miss",  32'(disp_miss),  0);
      chk("rst_host_done",  32'(host_done),  0);
      chk("rst_ram_we",     32'(ram_we),     0);
      chk("rst_host_rdata", 32'(host_rdata), 0);
      ram_ld = 1'b0;
      rst_n  = 1'b1;
      nxt(); #1;
      chk("ready_after_release", 32'(host_ready), 1);

      // Display only
      disp_req = 1'b1; disp_addr = 10'h005; #1;
      chk("disp_ram_we",   32'(ram_we),   0);
      chk("disp_ram_addr", 32'(ram_addr), 'h005);
      nxt(); disp_req = 1'b0; #1;
      chk("disp_valid",      32'(disp_valid), 1);
      chk("disp_data",       32'(disp_data),  'h5);
      chk("disp_no_miss",    32'(disp_miss),  0);
      nxt(); #1;
      chk("disp_valid_pulse", 32'(disp_valid), 0);

      // Host write with display idle
      nxt();
      host_valid = 1'b1; host_we = 1'b1; host_addr = 10'h010; host_wdata = 4'hA; #1;
      chk("wr_accept_ready", 32'(host_ready), 1);
      chk("wr_no_same_gnt",  32'(ram_we),     0);
      nxt(); host_valid = 1'b0; #1;
      chk("wr_ram_we",    32'(ram_we),     1);
      chk("wr_ram_addr",  32'(ram_addr),   'h010);
      chk("wr_ram_wdata", 32'(ram_wdata),  'hA);
      chk("wr_busy",      32'(host_ready), 0);
      chk("wr_done_early", 32'(host_done), 0);
      nxt(); #1;
      chk("wr_done",  32'(host_done),  1);
      chk("wr_ready", 32'(host_ready), 1);
      nxt(); disp_req = 1'b1; disp_addr = 10'h010; #1;
      chk("wr_done_pulse", 32'(host_done), 0);
      nxt(); disp_req = 1'b0; #1;
      chk("wr_readback_valid", 32'(disp_valid), 1);
      chk("wr_readback_data",  32'(disp_data),  'hA);

      // Host read with display idle
      nxt();
      host_valid = 1'b1; host_we = 1'b0; host_addr = 10'h023; #1;
      nxt(); host_valid = 1'b0; #1;
      chk("rd_g_we",   32'(ram_we),   0);
      chk("rd_g_addr", 32'(ram_addr), 'h023);
      nxt(); #1;
      chk("rd_g1_done",  32'(host_done),  0);
      chk("rd_g1_ready", 32'(host_ready), 0);
      nxt(); #1;
      chk("rd_g2_done",  32'(host_done),  1);
      chk("rd_g2_rdata", 32'(host_rdata), 'h3);
      chk("rd_g2_ready", 32'(host_ready), 1);
      nxt(); #1;
      chk("rd_done_pulse", 32'(host_done),  0);
      chk("rd_rdata_hold", 32'(host_rdata), 'h3);

      // Starvation: display held busy while a host write waits
      nxt();
      disp_req = 1'b1; disp_addr = 10'h001;
      host_valid = 1'b1; host_we = 1'b1; host_addr = 10'h030; host_wdata = 4'h7; #1;
      chk("st_accept_ready", 32'(host_ready), 1);
      nxt(); host_valid = 1'b0;
      for (int k = 1; k <= LIM; k++) begin
         #1;
         chk("st_blocked_we", 32'(ram_we), 0);
         nxt();
      end
      #1;
      chk("st_override_we",   32'(ram_we),     1);
      chk("st_override_addr", 32'(ram_addr),   'h030);
      chk("st_prev_valid",    32'(disp_valid), 1);
      nxt(); disp_req = 1'b0; #1;
      chk("st_miss",      32'(disp_miss),   1);
      chk("st_no_valid",  32'(disp_valid),  0);
      chk("st_done",      32'(host_done),   1);
      chk("st_wait_zero", 32'(dut.wait_q),  0);
      nxt(); #1;
      chk("st_miss_pulse", 32'(disp_miss), 0);

      // Display request while the host read is in its response cycle
      nxt();
      host_valid = 1'b1; host_we = 1'b0; host_addr = 10'h024; #1;
      nxt(); host_valid = 1'b0;
      nxt(); disp_req = 1'b1; disp_addr = 10'h007; #1;
      chk("sim_resp_addr", 32'(ram_addr), 'h007);
      chk("sim_resp_we",   32'(ram_we),   0);
      nxt(); disp_req = 1'b0; #1;
      chk("sim_done",       32'(host_done),  1);
      chk("sim_rdata",      32'(host_rdata), 'h4);
      chk("sim_disp_valid", 32'(disp_valid), 1);
      chk("sim_disp_data",  32'(disp_data),  'h7);
      chk("sim_no_miss",    32'(disp_miss),  0);

      // Reset while a read sits in its response cycle
      nxt();
      host_valid = 1'b1; host_we = 1'b0; host_addr = 10'h025; #1;
      nxt(); host_valid = 1'b0;
      nxt(); disp_req = 1'b1; disp_addr = 10'h009; #1;
      rst_n = 1'b0; #1;
      chk("rr_done",  32'(host_done),  0);
      chk("rr_valid", 32'(disp_valid), 0);
      chk("rr_ready", 32'(host_ready), 1);
      chk("rr_rdata", 32'(host_rdata), 0);
      nxt(); disp_req = 1'b0; #1;
      chk("rr_hold_done",  32'(host_done),  0);
      chk("rr_hold_valid", 32'(disp_valid), 0);
      rst_n = 1'b1;
      nxt(); #1;
      chk("rr_rel_ready", 32'(host_ready), 1);
      chk("rr_rel_done",  32'(host_done),  0);
      chk("rr_rel_valid", 32'(disp_valid), 0);
      chk("rr_rel_miss",  32'(disp_miss),  0);
      chk("rr_rel_we",    32'(ram_we),     0);

      // Random phase: display low addresses, host upper addresses.
      for (int a = 0; a < 1024; a++) ref_mem[a] = a[DW-1:0];
      ref_mem[10'h010] = 4'hA;
      ref_mem[10'h030] = 4'h7;
      for (int t = 0; t < M; t++) begin
         disp_pat[t]  = (t < N) && ($urandom_range(0, 9) < 8);
         dpat_addr[t] = AW'($urandom_range(0, 255));
      end
      free_at = 0;
      for (int t = 0; t < T; t++) begin
         nxt();
         disp_req   = disp_pat[t];
         disp_addr  = dpat_addr[t];
         hv         = (t < N) && ($urandom_range(0, 2) == 0);
         host_valid = hv;
         host_we    = 1'($urandom_range(0, 1));
         host_addr  = 10'h200 | AW'($urandom_range(0, 255));
         host_wdata = DW'($urandom_range(0, 15));
         rdy = (t >= free_at);
         if (hv && rdy) begin
            // Host is granted at the first quiet display cycle, or once it
            // has sat out LIM blocked cycles.
            g = t + 1;
            while (disp_pat[g] && (g - t - 1) != LIM) g++;
            exp_we[g] = host_we;
            if (disp_pat[g]) begin
               ovr[g]          = 1'b1;
               exp_miss[g + 1] = 1'b1;
            end
            d = host_we ? g + 1 : g + 2;
            exp_done[d] = 1'b1;
            free_at = d;
            if (host_we) begin
               ref_mem[host_addr] = host_wdata;
            end else begin
               exp_isrd[d] = 1'b1;
               exp_rd[d]   = ref_mem[host_addr];
            end
         end
         if (disp_pat[t] && !ovr[t]) begin
            exp_valid[t + 1] = 1'b1;
            exp_ddata[t + 1] = ref_mem[disp_addr];
         end
         #1;
         chk("rnd_ready", 32'(host_ready), 32'(rdy));
         chk("rnd_we",    32'(ram_we),     32'(exp_we[t]));
         chk("rnd_valid", 32'(disp_valid), 32'(exp_valid[t]));
         chk("rnd_miss",  32'(disp_miss),  32'(exp_miss[t]));
         chk("rnd_done",  32'(host_done),  32'(exp_done[t]));
         if (exp_valid[t]) chk("rnd_ddata", 32'(disp_data), 32'(exp_ddata[t]));
         if (exp_isrd[t])  chk("rnd_rdata", 32'(host_rdata), 32'(exp_rd[t]));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
